// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned DATA_LEN = 32;

  localparam logic [DATA_LEN-1:0] DEFAULT_RST_PC   = 32'h8000_0000;
  localparam logic [31:0]         DEFAULT_NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]         inst;
    logic [DATA_LEN-1:0] pc;
    logic                fault;
  } fetch_entry_t;

  // A faulting fetch carries a NOP so decode never sees garbage data.
  function automatic fetch_entry_t make_entry(input logic [31:0]         data,
                                              input logic [DATA_LEN-1:0] pc,
                                              input logic                err,
                                              input logic [31:0]         nop);
    fetch_entry_t e;
    e.inst  = err ? nop : data;
    e.pc    = pc;
    e.fault = err;
    return e;
  endfunction

endpackage

// File: rtl/ifu_resp_buf.sv
// One-entry skid buffer holding a fetch response while the IF_ID slot is occupied.
module ifu_resp_buf
  import ifu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output logic         full,
  output fetch_entry_t entry
);

  logic         full_q, full_d;
  fetch_entry_t entry_q, entry_d;

  // Push and pop in the same cycle replace the entry and keep the buffer full.
  always_comb begin
    full_d  = full_q;
    entry_d = entry_q;
    if (flush) begin
      full_d = 1'b0;
    end else if (push) begin
      full_d  = 1'b1;
      entry_d = push_entry;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
    end
  end

  assign full  = full_q;
  assign entry = entry_q;

endmodule

// File: rtl/ifu.sv
// Instruction fetch stage: PC, single-outstanding memory requests, IF_ID slot and redirect handling.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [DATA_LEN-1:0] RST_PC   = DEFAULT_RST_PC,
  parameter logic [31:0]         NOP_INST = DEFAULT_NOP_INST
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                inst_req_valid,
  input  logic                inst_req_ready,
  output logic [DATA_LEN-1:0] inst_req_addr,
  input  logic                inst_resp_valid,
  input  logic [31:0]         inst_resp_data,
  input  logic                inst_resp_err,
  output logic [31:0]         IF_ID_reg_inst,
  output logic [DATA_LEN-1:0] IF_ID_reg_PC,
  output logic                IF_ID_reg_inst_valid,
  output logic                IF_ID_reg_inst_fault,
  input  logic                ID_reg_decode_enable,
  input  logic                EX_IF_jump_flag,
  input  logic [DATA_LEN-1:0] EX_IF_jump_pc
);

  fetch_state_e        state_q, state_d;
  logic [DATA_LEN-1:0] pc_q, pc_d;
  logic [DATA_LEN-1:0] req_addr_q, req_addr_d;
  logic [DATA_LEN-1:0] inflight_pc_q, inflight_pc_d;
  logic                drop_q, drop_d;

  logic [31:0]         if_id_inst_q, if_id_inst_d;
  logic [DATA_LEN-1:0] if_id_pc_q, if_id_pc_d;
  logic                if_id_valid_q, if_id_valid_d;
  logic                if_id_fault_q, if_id_fault_d;

  logic         jump, handshake, resp_take, resp_live, consume, slot_free, credit;
  logic         buf_full, buf_push, buf_pop, buf_full_next;
  fetch_entry_t resp_entry, buf_entry;

  assign jump      = EX_IF_jump_flag;
  assign handshake = (state_q == StReq) & inst_req_ready;
  assign resp_take = (state_q == StWait) & inst_resp_valid;
  // Redirect wins over a landing response, as does a pending drop.
  assign resp_live = resp_take & ~drop_q & ~jump;
  assign consume   = if_id_valid_q & ID_reg_decode_enable;
  assign slot_free = ~if_id_valid_q | consume;

  assign resp_entry = make_entry(inst_resp_data, inflight_pc_q, inst_resp_err, NOP_INST);

  // The buffer always drains first so program order is preserved.
  assign buf_pop  = buf_full & slot_free & ~jump;
  assign buf_push = resp_live & (buf_full | ~slot_free);

  assign buf_full_next = jump     ? 1'b0 :
                         buf_push ? 1'b1 :
                         buf_pop  ? 1'b0 : buf_full;

  ifu_resp_buf u_resp_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (buf_push),
    .pop        (buf_pop),
    .flush      (jump),
    .push_entry (resp_entry),
    .full       (buf_full),
    .entry      (buf_entry)
  );

  always_comb begin
    if_id_inst_d  = if_id_inst_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_valid_d = if_id_valid_q;
    if_id_fault_d = if_id_fault_q;
    if (jump) begin
      if_id_valid_d = 1'b0;
      if_id_inst_d  = NOP_INST;
      if_id_fault_d = 1'b0;
    end else if (slot_free) begin
      if (buf_full) begin
        if_id_inst_d  = buf_entry.inst;
        if_id_pc_d    = buf_entry.pc;
        if_id_fault_d = buf_entry.fault;
        if_id_valid_d = 1'b1;
      end else if (resp_live) begin
        if_id_inst_d  = resp_entry.inst;
        if_id_pc_d    = resp_entry.pc;
        if_id_fault_d = resp_entry.fault;
        if_id_valid_d = 1'b1;
      end else begin
        if_id_valid_d = 1'b0;
        if_id_fault_d = 1'b0;
      end
    end
  end

  // A new request may be issued only if IF_ID and the buffer will not both be occupied.
  assign credit = ~(if_id_valid_d & buf_full_next);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    inflight_pc_d = inflight_pc_q;
    drop_d        = drop_q;

    unique case (state_q)
      StIdle: begin
        if (credit) state_d = StReq;
      end
      StReq: begin
        if (inst_req_ready) begin
          state_d       = StWait;
          inflight_pc_d = req_addr_q;
          // A request redirected while stalled already has pc pointing at the target.
          if (!drop_q) pc_d = pc_q + DATA_LEN'(4);
        end
      end
      StWait: begin
        if (inst_resp_valid) begin
          drop_d  = 1'b0;
          state_d = credit ? StReq : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (jump) begin
      pc_d = EX_IF_jump_pc;
      if ((state_q == StReq) || ((state_q == StWait) && !inst_resp_valid)) drop_d = 1'b1;
    end

    // The address is latched on entry to REQ and held until accepted.
    if ((state_d == StReq) && (state_q != StReq)) req_addr_d = pc_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= RST_PC;
      req_addr_q    <= RST_PC;
      inflight_pc_q <= RST_PC;
      drop_q        <= 1'b0;
      if_id_inst_q  <= NOP_INST;
      if_id_pc_q    <= RST_PC;
      if_id_valid_q <= 1'b0;
      if_id_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      inflight_pc_q <= inflight_pc_d;
      drop_q        <= drop_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_fault_q <= if_id_fault_d;
    end
  end

  assign inst_req_valid       = (state_q == StReq);
  assign inst_req_addr        = req_addr_q;
  assign IF_ID_reg_inst       = if_id_inst_q;
  assign IF_ID_reg_PC         = if_id_pc_q;
  assign IF_ID_reg_inst_valid = if_id_valid_q;
  assign IF_ID_reg_inst_fault = if_id_fault_q;

endmodule
